// File: rtl/ascon_pkg.sv
// Shared constants, sequencer state encoding and round-constant helper for the Ascon permutation engine.
package ascon_pkg;
    localparam int ASCON_ROUNDS_A  = 12;
    localparam int ASCON_ROUNDS_B6 = 6;
    localparam int ASCON_ROUNDS_B8 = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

    // Round index i maps to the constant {15-i, i}; i runs from 12-N up to 11.
    function automatic logic [7:0] ascon_rc(input logic [3:0] i);
        return {4'(4'd15 - i), i};
    endfunction
endpackage

// File: rtl/ascon_p.sv
// One combinational Ascon round: constant addition on x2, 5-bit S-box layer, linear diffusion.
module ascon_p (
    input  logic [63:0] x0_in,
    input  logic [63:0] x1_in,
    input  logic [63:0] x2_in,
    input  logic [63:0] x3_in,
    input  logic [63:0] x4_in,
    input  logic [7:0]  c_r,
    output logic [63:0] x0_out,
    output logic [63:0] x1_out,
    output logic [63:0] x2_out,
    output logic [63:0] x3_out,
    output logic [63:0] x4_out
);
    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
    logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
    logic [63:0] w_d0, w_d1, w_d2, w_d3, w_d4;

    // Bitsliced S-box: input mixing, chi-like core, output mixing.
    assign w_b0 = x0_in ^ x4_in;
    assign w_b1 = x1_in;
    assign w_b2 = x2_in ^ {56'd0, c_r} ^ x1_in;
    assign w_b3 = x3_in;
    assign w_b4 = x4_in ^ x3_in;

    assign w_c0 = w_b0 ^ (~w_b1 & w_b2);
    assign w_c1 = w_b1 ^ (~w_b2 & w_b3);
    assign w_c2 = w_b2 ^ (~w_b3 & w_b4);
    assign w_c3 = w_b3 ^ (~w_b4 & w_b0);
    assign w_c4 = w_b4 ^ (~w_b0 & w_b1);

    assign w_d0 = w_c0 ^ w_c4;
    assign w_d1 = w_c1 ^ w_c0;
    assign w_d2 = ~w_c2;
    assign w_d3 = w_c3 ^ w_c2;
    assign w_d4 = w_c4;

    assign x0_out = w_d0 ^ ror(w_d0, 19) ^ ror(w_d0, 28);
    assign x1_out = w_d1 ^ ror(w_d1, 61) ^ ror(w_d1, 39);
    assign x2_out = w_d2 ^ ror(w_d2, 1)  ^ ror(w_d2, 6);
    assign x3_out = w_d3 ^ ror(w_d3, 10) ^ ror(w_d3, 17);
    assign x4_out = w_d4 ^ ror(w_d4, 7)  ^ ror(w_d4, 41);
endmodule

// File: rtl/ascon_perm_seq.sv
// Iterative Ascon permutation sequencer: one ascon_p round per clock, valid/ready on both sides.
// Optional ASCON_PERM_SEQ_ABORT_EN adds an abort input that drops and zeroes an in-flight operation.
module ascon_perm_seq
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = ASCON_ROUNDS_A,
    parameter int RCNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RCNT_W-1:0] n_rounds,
    input  logic [63:0]       x0_in,
    input  logic [63:0]       x1_in,
    input  logic [63:0]       x2_in,
    input  logic [63:0]       x3_in,
    input  logic [63:0]       x4_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       x0_out,
    output logic [63:0]       x1_out,
    output logic [63:0]       x2_out,
    output logic [63:0]       x3_out,
    output logic [63:0]       x4_out,
    output logic              busy
`ifdef ASCON_PERM_SEQ_ABORT_EN
    ,
    input  logic              abort
`endif
);
    localparam logic [RCNT_W-1:0] MAXR    = RCNT_W'(MAX_ROUNDS);
    localparam logic [RCNT_W-1:0] MAXR_M1 = RCNT_W'(MAX_ROUNDS - 1);

    seq_state_e        r_state, w_state_d;
    logic [4:0][63:0]  r_x;
    logic [RCNT_W-1:0] r_rnd;
    logic [RCNT_W-1:0] w_n;
    logic [7:0]        w_rc;
    logic [4:0][63:0]  w_p;
    logic              w_load, w_step, w_clear, w_abort;

`ifdef ASCON_PERM_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_n  = (n_rounds > MAXR) ? MAXR : n_rounds;
    assign w_rc = ascon_rc(r_rnd[3:0]);

    ascon_p u_round (
        .x0_in (r_x[0]), .x1_in (r_x[1]), .x2_in (r_x[2]), .x3_in (r_x[3]), .x4_in (r_x[4]),
        .c_r   (w_rc),
        .x0_out(w_p[0]), .x1_out(w_p[1]), .x2_out(w_p[2]), .x3_out(w_p[3]), .x4_out(w_p[4])
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            IDLE: if (in_valid) begin
                w_load    = 1'b1;
                w_state_d = (w_n == '0) ? DONE : RUN;
            end
            RUN: begin
                w_step = 1'b1;
                if (r_rnd == MAXR_M1) w_state_d = DONE;
            end
            DONE: if (out_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
        // Abort wipes the partial state so nothing intermediate stays visible on x*_out.
        if (w_abort && (r_state != IDLE)) begin
            w_state_d = IDLE;
            w_load    = 1'b0;
            w_step    = 1'b0;
            w_clear   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_x   <= '0;
            r_rnd <= '0;
        end else if (w_load) begin
            r_x   <= {x4_in, x3_in, x2_in, x1_in, x0_in};
            r_rnd <= MAXR - w_n;
        end else if (w_step) begin
            r_x   <= w_p;
            r_rnd <= r_rnd + 1'b1;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign x0_out    = r_x[0];
    assign x1_out    = r_x[1];
    assign x2_out    = r_x[2];
    assign x3_out    = r_x[3];
    assign x4_out    = r_x[4];
endmodule

// File: tb/tb_ascon_perm_seq.sv
// Scoreboard bench for ascon_perm_seq: table-driven S-box reference model, latency and round-constant probing.
module tb_ascon_perm_seq;
    typedef logic [4:0][63:0] st_t;
    typedef struct { st_t st; int n; } exp_t;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
    logic [3:0]  n_rounds = 0;
    logic [63:0] x0_in = 0, x1_in = 0, x2_in = 0, x3_in = 0, x4_in = 0;
    logic [63:0] x0_out, x1_out, x2_out, x3_out, x4_out;
`ifdef ASCON_PERM_SEQ_ABORT_EN
    logic        abort = 0;
`endif

    ascon_perm_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .n_rounds(n_rounds),
        .x0_in(x0_in), .x1_in(x1_in), .x2_in(x2_in), .x3_in(x3_in), .x4_in(x4_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_out(x0_out), .x1_out(x1_out), .x2_out(x2_out), .x3_out(x3_out), .x4_out(x4_out),
        .busy(busy)
`ifdef ASCON_PERM_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
    bit   seen_v = 1;
    exp_t q[$];
    logic [7:0] rc_log[$];
    st_t  STD, ALT;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic st_t mround(input st_t s, input logic [7:0] rc);
        st_t t;
        logic [4:0] idx, o;
        s[2][7:0] = s[2][7:0] ^ rc;
        for (int b = 0; b < 64; b++) begin
            idx = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o = SBOX[idx];
            t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
        end
        t[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
        t[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
        t[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
        t[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
        t[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        return t;
    endfunction

    function automatic logic [7:0] mrc(input int i);
        return 8'((15 - i) * 16 + i);
    endfunction

    function automatic st_t mperm(input st_t s, input int n);
        for (int i = 12 - n; i < 12; i++) s = mround(s, mrc(i));
        return s;
    endfunction

    function automatic st_t outs();
        return {x4_out, x3_out, x2_out, x1_out, x0_out};
    endfunction

    // Monitor: tracks accept time, logs the probed round constant while busy, checks on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            rc_log.delete();
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc = cyc; rc_log.delete(); seen_v = 0;
            end
            if (busy) rc_log.push_back(dut.w_rc);
            if (out_valid && !seen_v) begin
                seen_v = 1;
                if (q.size() == 0) chk("unexpected_valid", 0, "out_valid=1 with no request pending, required 0");
                else chk("latency", (cyc - acc_cyc) == q[0].n + 1,
                         $sformatf("got %0d cycles, required %0d", cyc - acc_cyc, q[0].n + 1));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_handshake", 0, "handshake with empty scoreboard");
                else begin
                    exp_t e;
                    bit ok;
                    e = q.pop_front();
                    chk($sformatf("state_n%0d", e.n), outs() == e.st,
                        $sformatf("got %h required %h", outs(), e.st));
                    ok = (rc_log.size() == e.n);
                    for (int j = 0; j < rc_log.size() && ok; j++)
                        if (rc_log[j] != mrc(12 - e.n + j)) ok = 0;
                    chk($sformatf("rc_seq_n%0d", e.n), ok,
                        $sformatf("got %0d consts first=%h, required %0d first=%h", rc_log.size(),
                                  (rc_log.size() > 0) ? rc_log[0] : 8'h00, e.n, mrc(12 - e.n)));
                end
            end
        end
    end

    task automatic issue(input int n, input st_t s, input bit push);
        int ne;
        ne = (n > 12) ? 12 : n;
        @(posedge clk); #1;
        {x4_in, x3_in, x2_in, x1_in, x0_in} = s;
        n_rounds = 4'(n);
        in_valid = 1;
        if (push) q.push_back('{st: mperm(s, ne), n: ne});
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (q.size() == 0 && in_ready) break;
        end
        if (k == 100) chk({name, "_timeout"}, 0, "no result within 100 cycles");
    endtask

    task automatic check_idle_zero(input string name);
        chk({name, "_in_ready"}, in_ready == 1, $sformatf("got %b required 1", in_ready));
        chk({name, "_out_valid"}, out_valid == 0, $sformatf("got %b required 0", out_valid));
        chk({name, "_busy"}, busy == 0, $sformatf("got %b required 0", busy));
        chk({name, "_zero"}, outs() == '0, $sformatf("got %h required 0", outs()));
    endtask

    task automatic no_valid_window(input string name);
        bit bad;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        chk({name, "_no_valid"}, !bad, "out_valid seen after abandon, required none");
    endtask

    initial begin
        STD = {64'h89abcde01234567f, 64'h6789abcdef012345, 64'h456789abcdef0123,
               64'h23456789abcdef01, 64'h0123456789abcdef};
        ALT = {64'hffffffffffffffff, 64'h0, 64'hdeadbeefcafef00d, 64'h1, 64'h8000000000000000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check_idle_zero("reset");

        issue(12, STD, 1); drain("n12");
        issue(6,  STD, 1); drain("n6");
        issue(8,  STD, 1); drain("n8");
        issue(0,  STD, 1); drain("n0");
        issue(15, STD, 1); drain("n15");
        issue(12, ALT, 1); drain("alt12");

        begin : backpressure
            st_t snap;
            bit stable, rdy_low;
            int k;
            out_ready = 0;
            issue(12, STD, 1);
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            chk("bp_reach_done", k < 40, "out_valid never rose");
            snap = outs(); stable = 1; rdy_low = 1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                in_valid = (c == 2);
                if (c == 2) {x4_in, x3_in, x2_in, x1_in, x0_in} = ALT;
                if (!out_valid || outs() != snap) stable = 0;
                if (in_ready) rdy_low = 0;
            end
            in_valid = 0;
            @(negedge clk);
            if (!out_valid || outs() != snap) stable = 0;
            chk("bp_stable", stable, $sformatf("got valid=%b %h required 1 %h", out_valid, outs(), snap));
            chk("bp_in_ready_low", rdy_low, "in_ready went high in DONE, required 0");
            @(posedge clk); #1 out_ready = 1;
            @(posedge clk); #1;
            chk("bp_release_valid", out_valid == 0, $sformatf("got %b required 0", out_valid));
            chk("bp_release_ready", in_ready == 1, $sformatf("got %b required 1", in_ready));
            chk("bp_no_extra", q.size() == 0, $sformatf("pending %0d required 0", q.size()));
        end

        issue(12, STD, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        check_idle_zero("rst_mid");
        no_valid_window("rst_mid");

`ifdef ASCON_PERM_SEQ_ABORT_EN
        issue(12, STD, 0);
        repeat (2) @(posedge clk);
        #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        check_idle_zero("abort");
        no_valid_window("abort");
`endif

        issue(8, ALT, 1); drain("recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
